hazard_controller: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It detects load-use hazards, squashes wrong-path instructions on taken branches, and sequences the multi-cycle MULT/DIV unit. It drives the PC and IF/ID write enables, the IF/ID and ID/EX flushes, the MULT/DIV start strobe and the HI/LO write strobe. It sits beside the forwarding logic in EX and covers the hazards that forwarding cannot resolve.

---
 rtl/hazard_controller_pkg.sv | 14 +
 rtl/hazard_controller_if.sv | 39 +++
 rtl/hazard_controller_muldiv_sequencer.sv | 66 ++++++
 rtl/hazard_controller.sv | 80 ++++++++
 tb/tb_hazard_controller.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller and its
// MULT/DIV sequencer.
package hazard_pkg;

    localparam int CNT_W           = 6;
    localparam int DEF_MULT_CYCLES = 4;
    localparam int DEF_DIV_CYCLES  = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-side bundle: hazard inputs from IF/ID and ID/EX, and the enables,
// flushes and MULT/DIV strobes going back out.
interface hazard_controller_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   ID_EX_MemRead;
    logic [4:0]             ID_EX_RegRt;
    logic                   ID_EX_is_muldiv;
    logic                   ID_EX_is_div;
    logic [4:0]             IF_ID_RegRs;
    logic [4:0]             IF_ID_RegRt;
    logic                   IF_ID_is_muldiv;
    logic                   IF_ID_uses_hilo;
    logic                   branch_taken;
    logic                   PC_write;
    logic                   IF_ID_write;
    logic                   IF_ID_flush;
    logic                   ID_EX_flush;
    logic                   muldiv_start;
    logic                   muldiv_busy;
    logic                   hilo_write;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output ID_EX_MemRead, ID_EX_RegRt, ID_EX_is_muldiv, ID_EX_is_div,
               IF_ID_RegRs, IF_ID_RegRt, IF_ID_is_muldiv, IF_ID_uses_hilo,
               branch_taken,
        input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush,
               muldiv_start, muldiv_busy, hilo_write, stall_count
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_RegRt, ID_EX_is_muldiv, ID_EX_is_div,
               IF_ID_RegRs, IF_ID_RegRt, IF_ID_is_muldiv, IF_ID_uses_hilo,
               branch_taken,
        output PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush,
               muldiv_start, muldiv_busy, hilo_write, stall_count
    );
endinterface

// File: rtl/hazard_controller_muldiv_sequencer.sv
// IDLE/RUN sequencer for the multi-cycle MULT/DIV unit: issues the start
// strobe, tracks the busy window and pulses hilo_write on the last cycle.
module muldiv_sequencer
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_is_muldiv,
    input  logic i_is_div,
    output logic o_start,
    output logic o_busy,
    output logic o_hilo_write,
    output logic o_run
);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Strobes are masked by reset so an aborted operation never writes HI/LO.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        o_start      = 1'b0;
        o_busy       = 1'b0;
        o_hilo_write = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_is_muldiv && !reset) begin
                    o_start     = 1'b1;
                    w_state_nxt = RUN;
                    w_cnt_nxt   = i_is_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            RUN: begin
                o_busy = !reset;
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    o_hilo_write = !reset;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_run = (r_state == RUN);

endmodule

// File: rtl/hazard_controller.sv
// Load-use / HI-LO stall detection with taken-branch squash priority, the
// saturating stall counter, and the MULT/DIV sequencer instance.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int STALL_CNT_W = 16
) (
    input logic                clk,
    input logic                reset,
    hazard_controller_if.slave io_hz
);
    logic                   w_start;
    logic                   w_busy;
    logic                   w_hilo_write;
    logic                   w_run;
    logic                   w_load_use;
    logic                   w_hilo_hazard;
    logic                   w_stall;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    muldiv_sequencer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_seq (
        .clk          (clk),
        .reset        (reset),
        .i_is_muldiv  (io_hz.ID_EX_is_muldiv),
        .i_is_div     (io_hz.ID_EX_is_div),
        .o_start      (w_start),
        .o_busy       (w_busy),
        .o_hilo_write (w_hilo_write),
        .o_run        (w_run)
    );

    assign w_load_use = io_hz.ID_EX_MemRead && (io_hz.ID_EX_RegRt != 5'd0) &&
                        ((io_hz.ID_EX_RegRt == io_hz.IF_ID_RegRs) ||
                         (io_hz.ID_EX_RegRt == io_hz.IF_ID_RegRt));

    // A MULT/DIV entering EX also blocks a dependent op in ID before RUN starts.
    assign w_hilo_hazard = (io_hz.IF_ID_uses_hilo || io_hz.IF_ID_is_muldiv) &&
                           (w_run || io_hz.ID_EX_is_muldiv);

    assign w_stall = (w_load_use || w_hilo_hazard) && !io_hz.branch_taken && !reset;

    always_comb begin
        io_hz.PC_write    = 1'b1;
        io_hz.IF_ID_write = 1'b1;
        io_hz.IF_ID_flush = 1'b0;
        io_hz.ID_EX_flush = 1'b0;
        if (reset) begin
            io_hz.PC_write    = 1'b0;
            io_hz.IF_ID_write = 1'b0;
            io_hz.IF_ID_flush = 1'b1;
            io_hz.ID_EX_flush = 1'b1;
        end else if (io_hz.branch_taken) begin
            io_hz.IF_ID_flush = 1'b1;
            io_hz.ID_EX_flush = 1'b1;
        end else if (w_stall) begin
            io_hz.PC_write    = 1'b0;
            io_hz.IF_ID_write = 1'b0;
            io_hz.ID_EX_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign io_hz.muldiv_start = w_start;
    assign io_hz.muldiv_busy  = w_busy;
    assign io_hz.hilo_write   = w_hilo_write;
    assign io_hz.stall_count  = reset ? '0 : r_stall_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: a tiny IF/ID/EX pipeline feeds two DUTs
// (16-bit and 4-bit stall counters) checked against a behavioural model.
module tb_hazard_controller;
    localparam int MC = 4;
    localparam int DC = 32;

    typedef struct packed {
        logic       ld;
        logic [4:0] rt;
        logic [4:0] rs;
        logic       md;
        logic       dv;
        logic       hl;
        logic       br;
    } ins_t;

    localparam ins_t NOP = '0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_controller_if #(.STALL_CNT_W(16)) hz ();
    hazard_controller_if #(.STALL_CNT_W(4))  hs ();

    assign hs.ID_EX_MemRead   = hz.ID_EX_MemRead;
    assign hs.ID_EX_RegRt     = hz.ID_EX_RegRt;
    assign hs.ID_EX_is_muldiv = hz.ID_EX_is_muldiv;
    assign hs.ID_EX_is_div    = hz.ID_EX_is_div;
    assign hs.IF_ID_RegRs     = hz.IF_ID_RegRs;
    assign hs.IF_ID_RegRt     = hz.IF_ID_RegRt;
    assign hs.IF_ID_is_muldiv = hz.IF_ID_is_muldiv;
    assign hs.IF_ID_uses_hilo = hz.IF_ID_uses_hilo;
    assign hs.branch_taken    = hz.branch_taken;

    hazard_controller #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .io_hz(hz.slave));
    hazard_controller #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .STALL_CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .io_hz(hs.slave));

    int errors = 0;
    int checks = 0;

    // Model state: remaining busy cycles of the unit, and ideal stall counts.
    int   m_left = 0;
    int   m_c16 = 0;
    int   m_c4 = 0;
    ins_t p_id = NOP;
    ins_t p_ex = NOP;
    ins_t prog[$];

    function automatic ins_t mk(logic ld, logic [4:0] rt, logic [4:0] rs,
                                logic md, logic dv, logic hl, logic br);
        return {ld, rt, rs, md, dv, hl, br};
    endfunction

    function automatic logic exp_stall();
        logic lu, hh;
        if (reset) return 1'b0;
        lu = hz.ID_EX_MemRead && (hz.ID_EX_RegRt != 5'd0) &&
             (hz.ID_EX_RegRt == hz.IF_ID_RegRs || hz.ID_EX_RegRt == hz.IF_ID_RegRt);
        hh = (hz.IF_ID_uses_hilo || hz.IF_ID_is_muldiv) && (m_left > 0 || hz.ID_EX_is_muldiv);
        return (lu || hh) && !hz.branch_taken;
    endfunction

    function automatic logic exp_start();
        return !reset && hz.ID_EX_is_muldiv && (m_left == 0);
    endfunction

    // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, start, busy, hilo_write}
    function automatic logic [6:0] exp_vec();
        logic st, br;
        if (reset) return 7'b0011000;
        st = exp_stall();
        br = hz.branch_taken;
        return {br | ~st, br | ~st, br, br | st, exp_start(), m_left > 0, m_left == 1};
    endfunction

    function automatic logic [6:0] dut_vec();
        return {hz.PC_write, hz.IF_ID_write, hz.IF_ID_flush, hz.ID_EX_flush,
                hz.muldiv_start, hz.muldiv_busy, hz.hilo_write};
    endfunction

    function automatic logic [6:0] sat_vec();
        return {hs.PC_write, hs.IF_ID_write, hs.IF_ID_flush, hs.ID_EX_flush,
                hs.muldiv_start, hs.muldiv_busy, hs.hilo_write};
    endfunction

    task automatic drive_from_pipe();
        hz.ID_EX_MemRead   = p_ex.ld;
        hz.ID_EX_RegRt     = p_ex.rt;
        hz.ID_EX_is_muldiv = p_ex.md;
        hz.ID_EX_is_div    = p_ex.dv;
        hz.branch_taken    = p_ex.br;
        hz.IF_ID_RegRs     = p_id.rs;
        hz.IF_ID_RegRt     = p_id.rt;
        hz.IF_ID_is_muldiv = p_id.md;
        hz.IF_ID_uses_hilo = p_id.hl;
    endtask

    // Clock edge: advance the model and the toy pipeline from pre-edge inputs.
    task automatic tick();
        logic st, start;
        @(posedge clk);
        st    = exp_stall();
        start = exp_start();
        if (reset) begin
            m_left = 0; m_c16 = 0; m_c4 = 0;
            p_id = NOP; p_ex = NOP;
        end else begin
            if (st) begin
                if (m_c16 < 65535) m_c16++;
                if (m_c4 < 15) m_c4++;
            end
            if (start) m_left = hz.ID_EX_is_div ? DC : MC;
            else if (m_left > 0) m_left--;
            if (hz.branch_taken) begin
                p_ex = NOP; p_id = NOP;
            end else if (st) begin
                p_ex = NOP;
            end else begin
                p_ex = p_id;
                p_id = (prog.size() > 0) ? prog.pop_front() : NOP;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        prog.delete();
        p_id = NOP; p_ex = NOP;
        drive_from_pipe();
        tick();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hz.ID_EX_MemRead   = 1'($urandom);
            hz.ID_EX_RegRt     = 5'($urandom);
            hz.ID_EX_is_muldiv = 1'($urandom);
            hz.ID_EX_is_div    = 1'($urandom);
            hz.branch_taken    = 1'($urandom);
            hz.IF_ID_RegRs     = 5'($urandom);
            hz.IF_ID_RegRt     = 5'($urandom);
            hz.IF_ID_is_muldiv = 1'($urandom);
            hz.IF_ID_uses_hilo = 1'($urandom);
            #1;
            checks++;
            if (dut_vec() !== 7'b0011000 || sat_vec() !== 7'b0011000 ||
                hz.stall_count !== 16'd0 || hs.stall_count !== 4'd0) begin
                errors++;
                $display("FAIL reset cyc=%0d got vec=%b/%b cnt=%0d/%0d want vec=0011000 cnt=0",
                         i, dut_vec(), sat_vec(), hz.stall_count, hs.stall_count);
            end
            tick();
            @(negedge clk);
        end
    endtask

    task automatic test_load_use();
        for (int v = 0; v < 2; v++) begin
            logic [4:0] r;
            int n_stall, want;
            r = (v == 0) ? 5'd8 : 5'd0;
            want = (v == 0) ? 1 : 0;
            n_stall = 0;
            do_reset();
            prog.push_back(mk(1'b1, r, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0));
            prog.push_back(mk(1'b0, 5'd4, r, 1'b0, 1'b0, 1'b0, 1'b0));
            for (int i = 0; i < 6; i++) begin
                drive_from_pipe();
                #1;
                checks++;
                if (dut_vec() !== exp_vec() || sat_vec() !== exp_vec() ||
                    hz.stall_count !== 16'(m_c16) || hs.stall_count !== 4'(m_c4)) begin
                    errors++;
                    $display("FAIL load_use r=%0d cyc=%0d got vec=%b/%b cnt=%0d/%0d want vec=%b cnt=%0d/%0d",
                             r, i, dut_vec(), sat_vec(), hz.stall_count, hs.stall_count, exp_vec(), m_c16, m_c4);
                end
                if (!hz.PC_write) n_stall++;
                tick();
                @(negedge clk);
            end
            checks++;
            if (n_stall != want || hz.stall_count !== 16'(want)) begin
                errors++;
                $display("FAIL load_use_bubbles r=%0d got stalls=%0d cnt=%0d want %0d", r, n_stall, hz.stall_count, want);
            end
        end
    endtask

    task automatic test_mult_mflo();
        int t_start, t_hilo, n_start;
        t_start = -1; t_hilo = -1; n_start = 0;
        do_reset();
        prog.push_back(mk(1'b0, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        prog.push_back(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 14; i++) begin
            drive_from_pipe();
            #1;
            checks++;
            if (dut_vec() !== exp_vec() || sat_vec() !== exp_vec() ||
                hz.stall_count !== 16'(m_c16) || hs.stall_count !== 4'(m_c4)) begin
                errors++;
                $display("FAIL mult_mflo cyc=%0d got vec=%b/%b cnt=%0d/%0d want vec=%b cnt=%0d/%0d",
                         i, dut_vec(), sat_vec(), hz.stall_count, hs.stall_count, exp_vec(), m_c16, m_c4);
            end
            if (hz.muldiv_start) begin n_start++; t_start = i; end
            if (hz.hilo_write) t_hilo = i;
            tick();
            @(negedge clk);
        end
        checks++;
        if (n_start != 1 || t_start < 0 || t_hilo - t_start != 4 || hz.stall_count !== 16'd5) begin
            errors++;
            $display("FAIL mult_mflo_timing got starts=%0d hilo_lat=%0d cnt=%0d want 1 4 5",
                     n_start, t_hilo - t_start, hz.stall_count);
        end
    endtask

    task automatic test_div_back_to_back();
        int t1, t2, n_hilo;
        t1 = -1; t2 = -1; n_hilo = 0;
        do_reset();
        prog.push_back(mk(1'b0, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0));
        prog.push_back(mk(1'b0, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 80; i++) begin
            drive_from_pipe();
            #1;
            checks++;
            if (dut_vec() !== exp_vec() || sat_vec() !== exp_vec() ||
                hz.stall_count !== 16'(m_c16) || hs.stall_count !== 4'(m_c4)) begin
                errors++;
                $display("FAIL div_b2b cyc=%0d got vec=%b/%b cnt=%0d/%0d want vec=%b cnt=%0d/%0d",
                         i, dut_vec(), sat_vec(), hz.stall_count, hs.stall_count, exp_vec(), m_c16, m_c4);
            end
            if (hz.muldiv_start) begin
                if (t1 < 0) t1 = i; else t2 = i;
            end
            if (hz.hilo_write) n_hilo++;
            tick();
            @(negedge clk);
        end
        checks++;
        if (t1 < 0 || t2 - t1 != 34 || hz.stall_count !== 16'd33 || n_hilo != 2) begin
            errors++;
            $display("FAIL div_b2b_timing got gap=%0d cnt=%0d hilo=%0d want 34 33 2",
                     t2 - t1, hz.stall_count, n_hilo);
        end
    endtask

    task automatic test_branch_over_stall();
        for (int v = 0; v < 2; v++) begin
            logic [3:0] want;
            do_reset();
            p_ex = mk(1'b1, 5'd8, 5'd1, 1'b0, 1'b0, 1'b0, (v == 0));
            p_id = mk(1'b0, 5'd9, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
            want = (v == 0) ? 4'b1111 : 4'b0001;
            drive_from_pipe();
            #1;
            checks++;
            if (dut_vec()[6:3] !== want || hz.stall_count !== 16'd0) begin
                errors++;
                $display("FAIL branch v=%0d got ctl=%b cnt=%0d want ctl=%b cnt=0",
                         v, dut_vec()[6:3], hz.stall_count, want);
            end
            tick();
            @(negedge clk);
            checks++;
            if (hz.stall_count !== 16'(1 - (v == 0)) || hz.stall_count !== 16'(m_c16)) begin
                errors++;
                $display("FAIL branch_count v=%0d got cnt=%0d want %0d", v, hz.stall_count, 1 - (v == 0));
            end
        end
    endtask

    task automatic test_reset_mid_div();
        int t_start, n_hilo;
        logic busy_after;
        t_start = -1; n_hilo = 0; busy_after = 1'b1;
        do_reset();
        prog.push_back(mk(1'b0, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 50; i++) begin
            reset = (t_start >= 0 && i == t_start + 10);
            drive_from_pipe();
            #1;
            checks++;
            if (dut_vec() !== exp_vec() || sat_vec() !== exp_vec() ||
                hz.stall_count !== 16'(m_c16) || hs.stall_count !== 4'(m_c4)) begin
                errors++;
                $display("FAIL reset_mid_div cyc=%0d got vec=%b/%b cnt=%0d/%0d want vec=%b cnt=%0d/%0d",
                         i, dut_vec(), sat_vec(), hz.stall_count, hs.stall_count, exp_vec(), m_c16, m_c4);
            end
            if (hz.muldiv_start && t_start < 0) t_start = i;
            if (hz.hilo_write) n_hilo++;
            if (t_start >= 0 && i == t_start + 11) busy_after = hz.muldiv_busy;
            tick();
            @(negedge clk);
        end
        reset = 1'b0;
        checks++;
        if (t_start < 0 || n_hilo != 0 || busy_after !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_div_abort got start=%0d hilo=%0d busy=%b want hilo=0 busy=0",
                     t_start, n_hilo, busy_after);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        hz.ID_EX_MemRead = 1'b1; hz.ID_EX_RegRt = 5'd8; hz.ID_EX_is_muldiv = 1'b0;
        hz.ID_EX_is_div = 1'b0; hz.branch_taken = 1'b0; hz.IF_ID_RegRs = 5'd8;
        hz.IF_ID_RegRt = 5'd1; hz.IF_ID_is_muldiv = 1'b0; hz.IF_ID_uses_hilo = 1'b0;
        for (int i = 0; i < 21; i++) begin
            #1;
            checks++;
            if (dut_vec() !== exp_vec() || sat_vec() !== exp_vec() ||
                hz.stall_count !== 16'(m_c16) || hs.stall_count !== 4'(m_c4)) begin
                errors++;
                $display("FAIL saturation cyc=%0d got vec=%b/%b cnt=%0d/%0d want vec=%b cnt=%0d/%0d",
                         i, dut_vec(), sat_vec(), hz.stall_count, hs.stall_count, exp_vec(), m_c16, m_c4);
            end
            if (i < 20) begin
                tick();
                @(negedge clk);
            end
        end
        checks++;
        if (hs.stall_count !== 4'd15 || hz.stall_count !== 16'd20) begin
            errors++;
            $display("FAIL saturation_final got cnt4=%0d cnt16=%0d want 15 20", hs.stall_count, hz.stall_count);
        end
        tick();
        @(negedge clk);
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            int ty;
            logic [4:0] a, b;
            ty = $urandom_range(0, 11);
            a  = 5'($urandom_range(0, 5));
            b  = 5'($urandom_range(0, 5));
            case (ty)
                0, 1, 2: prog.push_back(mk(1'b1, a, b, 1'b0, 1'b0, 1'b0, 1'b0));
                3:       prog.push_back(mk(1'b0, a, b, 1'b1, 1'b0, 1'b0, 1'b0));
                4:       prog.push_back(mk(1'b0, a, b, 1'b1, 1'b1, 1'b0, 1'b0));
                5, 6:    prog.push_back(mk(1'b0, a, b, 1'b0, 1'b0, 1'b1, 1'b0));
                7:       prog.push_back(mk(1'b0, a, b, 1'b0, 1'b0, 1'b0, 1'b1));
                default: prog.push_back(mk(1'b0, a, b, 1'b0, 1'b0, 1'b0, 1'b0));
            endcase
        end
        for (int i = 0; i < 600; i++) begin
            drive_from_pipe();
            #1;
            checks++;
            if (dut_vec() !== exp_vec() || sat_vec() !== exp_vec() ||
                hz.stall_count !== 16'(m_c16) || hs.stall_count !== 4'(m_c4)) begin
                errors++;
                $display("FAIL random cyc=%0d got vec=%b/%b cnt=%0d/%0d want vec=%b cnt=%0d/%0d",
                         i, dut_vec(), sat_vec(), hz.stall_count, hs.stall_count, exp_vec(), m_c16, m_c4);
            end
            tick();
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load_use();
        test_mult_mflo();
        test_div_back_to_back();
        test_branch_over_stall();
        test_reset_mid_div();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no completion want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
